// File: rtl/router_pkg.sv
// Shared types, constants and helpers for the router packet register stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

   localparam int CHECK_XOR = 0;
   localparam int CHECK_SUM = 1;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int DEF_NUM_PORTS = 3;
   localparam int DEF_ADDR_W    = clog2(DEF_NUM_PORTS);

   // Destination address field in the low bits of a header byte.
   typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/router_hold_fifo.sv
// Circular holding queue for bytes that arrive while the output FIFO is full.
// Latency: registered; a pushed byte is visible at head_o the next cycle.
// Backpressure: push while full without a pop is ignored; pop while empty is ignored.
module router_hold_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] push_dat_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full queue may accept a push alongside a pop.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Storage, pointers and occupancy.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/router_pkt_reg_gen.sv
// Header latch, payload/parity write path to the output FIFO, packet check and hold queue.
// Latency: one cycle from a state input to dout/dout_valid.
// Backpressure: fifo_full diverts bytes into the hold queue; laf_state drains it; overflow drops and flags.
module router_pkt_reg_gen
   import router_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int NUM_PORTS  = 3,
   parameter int HOLD_DEPTH = 2,
   parameter int CHECK_MODE = 0,
   localparam int ADDR_W    = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS),
   localparam int CNT_W     = clog2(HOLD_DEPTH + 1)
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              rst_int_reg,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [CNT_W-1:0]  hold_count,
   output logic              hold_ovf,
   output logic              hdr_invalid,
   output logic              parity_done,
   output logic              low_packet_valid,
   output logic              err
);

   logic [DATA_W-1:0] header_q;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] temp_parity_q;
   logic              hold_ovf_q;
   logic              hdr_invalid_q;
   logic              parity_done_q;
   logic              err_q;
   logic              low_pv_q;
   logic              pcap_q;
   logic              pcap2_q;

   logic              hf_push, hf_pop, hf_full, hf_empty;
   logic [DATA_W-1:0] hf_head;

   logic [ADDR_W-1:0] hdr_addr;
   logic              addr_ok;
   logic              hdr_capture;
   logic              hdr_bad;
   logic              ovf_drop;
   logic              parity_byte;
   logic              payload_byte;

   function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      if (CHECK_MODE == CHECK_SUM) begin
         return a + b;
      end
      return a ^ b;
   endfunction

   assign hdr_addr     = data_in[ADDR_W-1:0];
   assign addr_ok      = ({1'b0, hdr_addr} < (ADDR_W + 1)'(NUM_PORTS));
   assign hdr_capture  = detect_add && pkt_valid && addr_ok;
   assign hdr_bad      = detect_add && pkt_valid && !addr_ok;
   assign parity_byte  = ld_state && !pkt_valid;
   assign payload_byte = ld_state && pkt_valid;
   assign ovf_drop     = hf_push && hf_full && !hf_pop;

   router_hold_fifo #(
      .DEPTH (HOLD_DEPTH),
      .WIDTH (DATA_W)
   ) u_hold (
      .clock      (clock),
      .resetn     (resetn),
      .push_i     (hf_push),
      .pop_i      (hf_pop),
      .push_dat_i (data_in),
      .head_o     (hf_head),
      .count_o    (hold_count),
      .full_o     (hf_full),
      .empty_o    (hf_empty)
   );

   // Select what goes to the output FIFO this cycle and steer bytes into/out of the hold queue.
   always_comb begin
      hf_push      = 1'b0;
      hf_pop       = 1'b0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (lfd_state) begin
         dout_d       = header_q;
         dout_valid_d = 1'b1;
      end else if (ld_state) begin
         if (fifo_full) begin
            hf_push = 1'b1;
         end else if (hf_empty) begin
            dout_d       = data_in;
            dout_valid_d = 1'b1;
         end else begin
            hf_push      = 1'b1;
            hf_pop       = 1'b1;
            dout_d       = hf_head;
            dout_valid_d = 1'b1;
         end
      end else if (laf_state && !fifo_full && !hf_empty) begin
         hf_pop       = 1'b1;
         dout_d       = hf_head;
         dout_valid_d = 1'b1;
      end
   end

   // Packet check accumulator: header plus every payload byte, held or dropped alike.
   always_comb begin
      acc_d = acc_q;
      if (detect_add) begin
         acc_d = '0;
      end else if (lfd_state) begin
         acc_d = fold(acc_q, header_q);
      end else if (payload_byte) begin
         acc_d = fold(acc_q, data_in);
      end
   end

   // Output register, header latch and accumulator.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         header_q      <= '0;
         acc_q         <= '0;
         temp_parity_q <= '0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         acc_q        <= acc_d;
         if (hdr_capture) begin
            header_q <= data_in;
         end
         if (parity_byte) begin
            temp_parity_q <= data_in;
         end
      end
   end

   // Sticky status flags, cleared at the start of each new packet.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         hdr_invalid_q <= 1'b0;
         hold_ovf_q    <= 1'b0;
         low_pv_q      <= 1'b0;
      end else begin
         if (hdr_bad) begin
            hdr_invalid_q <= 1'b1;
         end else if (detect_add) begin
            hdr_invalid_q <= 1'b0;
         end
         if (detect_add) begin
            hold_ovf_q <= 1'b0;
         end else if (ovf_drop) begin
            hold_ovf_q <= 1'b1;
         end
         if (payload_byte) begin
            low_pv_q <= 1'b1;
         end else if (rst_int_reg) begin
            low_pv_q <= 1'b0;
         end
      end
   end

   // Parity-byte capture -> parity_done one edge later -> err compare one edge after that.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         pcap_q        <= 1'b0;
         pcap2_q       <= 1'b0;
         parity_done_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         pcap_q  <= parity_byte && !detect_add;
         pcap2_q <= pcap_q && !detect_add;
         if (detect_add) begin
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
         end else begin
            if (pcap_q) begin
               parity_done_q <= 1'b1;
            end
            if (pcap2_q) begin
               err_q <= (temp_parity_q != acc_q);
            end
         end
      end
   end

   assign dout             = dout_q;
   assign dout_valid       = dout_valid_q;
   assign hold_ovf         = hold_ovf_q;
   assign hdr_invalid      = hdr_invalid_q;
   assign parity_done      = parity_done_q;
   assign low_packet_valid = low_pv_q;
   assign err              = err_q;

   // The FSM drives its state inputs one-hot.
   a_state_onehot: assert property (@(posedge clock) disable iff (!resetn)
      $onehot0({detect_add, lfd_state, ld_state, laf_state, rst_int_reg}));

endmodule

// File: tb/tb_router_pkt_reg_gen.sv
// Bench for the router packet register stage: XOR and SUM instances share one stimulus stream.
// Latency: model expects outputs one edge after the driving state input.
// Backpressure: fifo_full patterns exercise hold, drain and overflow.
module tb_router_pkt_reg_gen;

   localparam int HD = 2;

   logic       clock = 1'b0;
   logic       resetn, pkt_valid, fifo_full;
   logic       detect_add, lfd_state, ld_state, laf_state, rst_int_reg;
   logic [7:0] data_in;

   logic [7:0] dx_dout, ds_dout;
   logic       dx_vld, ds_vld;
   logic [1:0] dx_hc, ds_hc;
   logic       dx_ovf, ds_ovf, dx_hinv, ds_hinv, dx_pd, ds_pd, dx_lpv, ds_lpv, dx_err, ds_err;

   always #5 clock = ~clock;

   router_pkt_reg_gen #(.DATA_W(8), .NUM_PORTS(3), .HOLD_DEPTH(HD), .CHECK_MODE(0)) dut_x (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .rst_int_reg(rst_int_reg), .data_in(data_in),
      .dout(dx_dout), .dout_valid(dx_vld), .hold_count(dx_hc), .hold_ovf(dx_ovf),
      .hdr_invalid(dx_hinv), .parity_done(dx_pd), .low_packet_valid(dx_lpv), .err(dx_err));

   router_pkt_reg_gen #(.DATA_W(8), .NUM_PORTS(3), .HOLD_DEPTH(HD), .CHECK_MODE(1)) dut_s (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .rst_int_reg(rst_int_reg), .data_in(data_in),
      .dout(ds_dout), .dout_valid(ds_vld), .hold_count(ds_hc), .hold_ovf(ds_ovf),
      .hdr_invalid(ds_hinv), .parity_done(ds_pd), .low_packet_valid(ds_lpv), .err(ds_err));

   // Reference model: bytes waiting in the hold queue, in arrival order, plus packet state.
   logic [7:0] m_held[$];
   logic [7:0] m_hdr, m_tp, m_accx, m_accs, m_dout;
   bit         m_vld, m_ovf, m_hinv, m_pd, m_errx, m_errs, m_lpv, m_h1, m_h2;

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;
   int  wr_cnt, max_hc;
   bit  seen44;
   logic [7:0] last_lfd_dout;

   logic [7:0] pl_q[$];
   bit         ff_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply the rules for one clock edge using the inputs that were present at that edge.
   task automatic model_step();
      if (!resetn) begin
         m_held.delete();
         m_hdr = 0; m_tp = 0; m_accx = 0; m_accs = 0; m_dout = 0;
         m_vld = 0; m_ovf = 0; m_hinv = 0; m_pd = 0; m_errx = 0; m_errs = 0;
         m_lpv = 0; m_h1 = 0; m_h2 = 0;
         return;
      end
      m_vld = 0;
      if (detect_add) begin
         m_pd = 0; m_errx = 0; m_errs = 0; m_accx = 0; m_accs = 0; m_ovf = 0; m_hinv = 0;
         m_h1 = 0; m_h2 = 0;
         if (pkt_valid) begin
            if (data_in[1:0] < 2'd3) m_hdr = data_in;
            else m_hinv = 1;
         end
      end else begin
         if (m_h1) m_pd = 1;
         if (m_h2) begin
            m_errx = (m_tp != m_accx);
            m_errs = (m_tp != m_accs);
         end
         m_h2 = m_h1;
         m_h1 = ld_state && !pkt_valid;
      end
      if (lfd_state) begin
         m_dout = m_hdr; m_vld = 1;
         m_accx = m_accx ^ m_hdr; m_accs = m_accs + m_hdr;
      end
      if (ld_state) begin
         if (pkt_valid) begin
            m_accx = m_accx ^ data_in; m_accs = m_accs + data_in; m_lpv = 1;
         end else begin
            m_tp = data_in;
         end
         if (fifo_full) begin
            if (m_held.size() < HD) m_held.push_back(data_in);
            else m_ovf = 1;
         end else begin
            m_held.push_back(data_in);
            m_dout = m_held.pop_front();
            m_vld  = 1;
         end
      end
      if (laf_state && !fifo_full && m_held.size() > 0) begin
         m_dout = m_held.pop_front();
         m_vld  = 1;
      end
      if (rst_int_reg && !(ld_state && pkt_valid)) m_lpv = 0;
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      if (mon_en) begin
         chk("x_dout_valid", 32'(dx_vld), 32'(m_vld));
         chk("x_dout", 32'(dx_dout), 32'(m_dout));
         chk("x_hold_count", 32'(dx_hc), 32'(m_held.size()));
         chk("x_hold_ovf", 32'(dx_ovf), 32'(m_ovf));
         chk("x_hdr_invalid", 32'(dx_hinv), 32'(m_hinv));
         chk("x_parity_done", 32'(dx_pd), 32'(m_pd));
         chk("x_low_packet_valid", 32'(dx_lpv), 32'(m_lpv));
         chk("x_err", 32'(dx_err), 32'(m_errx));
         chk("s_dout_valid", 32'(ds_vld), 32'(m_vld));
         chk("s_dout", 32'(ds_dout), 32'(m_dout));
         chk("s_hold_count", 32'(ds_hc), 32'(m_held.size()));
         chk("s_parity_done", 32'(ds_pd), 32'(m_pd));
         chk("s_err", 32'(ds_err), 32'(m_errs));
         if (dx_vld) wr_cnt++;
         if (int'(dx_hc) > max_hc) max_hc = int'(dx_hc);
         if (dx_vld && dx_dout == 8'h44) seen44 = 1;
      end
   end

   task automatic tick(input bit rn, input bit da, input bit lfd, input bit ld, input bit laf,
                       input bit rir, input bit pv, input bit ff, input logic [7:0] d);
      resetn = rn; detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
      rst_int_reg = rir; pkt_valid = pv; fifo_full = ff; data_in = d;
      @(posedge clock);
      model_step();
      #1;
      if (lfd) last_lfd_dout = dx_dout;
      mon_en = 1'b1;
   endtask

   task automatic drain(input bit rnd);
      for (int k = 0; k < 40 && m_held.size() > 0; k++)
         tick(1, 0, 0, 0, 1, 0, 0, rnd ? ($urandom_range(0, 3) == 0) : 1'b0, 8'($urandom));
      for (int k = 0; k < HD + 1 && m_held.size() > 0; k++)
         tick(1, 0, 0, 0, 1, 0, 0, 0, 8'($urandom));
   endtask

   // One packet: header, lfd, payload from pl_q, parity byte; ff_q gives fifo_full per ld byte.
   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par, input bit rnd);
      int n;
      n = pl_q.size();
      tick(1, 1, 0, 0, 0, 0, 1, 0, hdr);
      tick(1, 0, 1, 0, 0, 0, 1, 0, 8'($urandom));
      for (int i = 0; i <= n; i++) begin
         tick(1, 0, 0, 1, 0, 0, i < n, ff_q[i], (i < n) ? pl_q[i] : par);
         if (ff_q[i] && (i == n || !ff_q[i + 1])) drain(rnd);
      end
      drain(rnd);
      tick(1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
      tick(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      tick(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   initial begin
      logic [7:0] hdr, h, par;
      int n;
      resetn = 0; pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0;
      ld_state = 0; laf_state = 0; rst_int_reg = 0; data_in = 0;
      wr_cnt = 0; max_hc = 0; seen44 = 0; last_lfd_dout = 0;

      tick(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("reset_dout", 32'(dx_dout), 0);
      chk("reset_dout_valid", 32'(dx_vld), 0);
      chk("reset_hold_count", 32'(dx_hc), 0);
      chk("reset_flags", 32'({dx_ovf, dx_hinv, dx_pd, dx_lpv, dx_err}), 0);

      // Basic XOR packet.
      pl_q = '{8'h11, 8'h22, 8'h33}; ff_q = '{0, 0, 0, 0}; wr_cnt = 0;
      send_pkt(8'h0D, 8'h0D, 0);
      chk("basic_model_xor", 32'(m_accx), 32'h0D);
      chk("basic_model_sum", 32'(m_accs), 32'h73);
      chk("basic_writes", 32'(wr_cnt), 5);
      chk("basic_parity_done", 32'(dx_pd), 1);
      chk("basic_err", 32'(dx_err), 0);

      // Bad parity, then err cleared by the next header.
      pl_q = '{8'h11, 8'h22, 8'h33}; ff_q = '{0, 0, 0, 0};
      send_pkt(8'h0D, 8'h0C, 0);
      chk("badpar_err", 32'(dx_err), 1);
      tick(1, 1, 0, 0, 0, 0, 1, 0, 8'h0D);
      chk("badpar_err_cleared", 32'(dx_err), 0);

      // Full stall on 0x22 and 0x33, drained in laf_state.
      pl_q = '{8'h11, 8'h22, 8'h33}; ff_q = '{0, 1, 1, 0}; wr_cnt = 0; max_hc = 0;
      send_pkt(8'h0D, 8'h0D, 0);
      chk("stall_max_hold", 32'(max_hc), 2);
      chk("stall_writes", 32'(wr_cnt), 5);
      chk("stall_err", 32'(dx_err), 0);

      // Overflow: 0x22, 0x33, 0x44 all arrive while full; 0x44 is dropped.
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44}; ff_q = '{0, 1, 1, 1, 0}; wr_cnt = 0; seen44 = 0;
      send_pkt(8'h0D, 8'h49, 0);
      chk("ovf_flag", 32'(dx_ovf), 1);
      chk("ovf_dropped_never_out", 32'(seen44), 0);
      chk("ovf_writes", 32'(wr_cnt), 5);

      // Invalid header keeps the previous header.
      pl_q = '{8'h11}; ff_q = '{0, 0};
      send_pkt(8'h0F, 8'h1C, 0);
      chk("badhdr_flag", 32'(dx_hinv), 1);
      chk("badhdr_kept_header", 32'(last_lfd_dout), 32'h0D);
      chk("badhdr_err", 32'(dx_err), 0);

      // Sum-mode parity.
      pl_q = '{8'h11, 8'h22, 8'h33}; ff_q = '{0, 0, 0, 0};
      send_pkt(8'h0D, 8'h73, 0);
      chk("sum_err", 32'(ds_err), 0);
      chk("sum_vs_xor_err", 32'(dx_err), 1);

      // Reset in the middle of a packet with one byte held.
      tick(1, 1, 0, 0, 0, 0, 1, 0, 8'h0D);
      tick(1, 0, 1, 0, 0, 0, 1, 0, 8'h00);
      tick(1, 0, 0, 1, 0, 0, 1, 0, 8'h11);
      tick(1, 0, 0, 1, 0, 0, 1, 1, 8'h22);
      chk("midrst_pre_hold", 32'(dx_hc), 1);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("midrst_dout", 32'(dx_dout), 0);
      chk("midrst_vld", 32'(dx_vld), 0);
      chk("midrst_hold", 32'(dx_hc), 0);
      chk("midrst_lpv", 32'(dx_lpv), 0);
      tick(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      tick(1, 0, 0, 0, 1, 0, 0, 0, 8'h00);

      // Randomized packets.
      for (int p = 0; p < 40; p++) begin
         n = $urandom_range(1, 5);
         pl_q.delete(); ff_q.delete();
         hdr = 8'($urandom);
         h = (hdr[1:0] != 2'b11) ? hdr : m_hdr;
         par = h;
         for (int i = 0; i < n; i++) begin
            pl_q.push_back(8'($urandom));
            ff_q.push_back($urandom_range(0, 2) == 0);
            par = par ^ pl_q[i];
         end
         ff_q.push_back($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) par = 8'($urandom);
         send_pkt(hdr, par, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_pkt_reg_gen.md
Name:
router_pkt_reg_gen

Overview:
- Parametrised datapath register stage between the router input FSM and the N output FIFOs.
- Latches and validates the header and delivers header/payload/parity bytes to the FIFO write path with an explicit write strobe.
- Buffers bytes that arrive while the target FIFO is full in a HOLD_DEPTH-deep holding queue.
- Accumulates a configurable packet check (XOR parity or modular sum) and flags mismatches.

Parameters:
- DATA_W, 8: byte/word width of data_in and dout.
- NUM_PORTS, 3: number of destination ports; the header address field is ADDR_W = clog2(NUM_PORTS) LSBs.
- HOLD_DEPTH, 2: entries in the holding queue, minimum 1.
- CHECK_MODE, 0: 0 = XOR parity, 1 = sum modulo 2^DATA_W.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- pkt_valid  in  1  packet byte valid from source; low marks the parity byte
- fifo_full  in  1  full flag of the selected output FIFO
- detect_add  in  1  FSM: header present on data_in
- lfd_state  in  1  FSM: load first data (header)
- ld_state  in  1  FSM: load payload/parity
- laf_state  in  1  FSM: load after full (drain hold queue)
- rst_int_reg  in  1  FSM: clear low_packet_valid
- data_in  in  DATA_W  byte from source
- dout  out  DATA_W  byte to output FIFO
- dout_valid  out  1  one-cycle write strobe qualifying dout
- hold_count  out  clog2(HOLD_DEPTH+1)  occupancy of the hold queue
- hold_ovf  out  1  sticky: a byte was dropped because the hold queue was full
- hdr_invalid  out  1  sticky: header address >= NUM_PORTS
- parity_done  out  1  packet check complete
- low_packet_valid  out  1  packet in progress
- err  out  1  check mismatch

Behaviour:
- Reset (resetn=0 at a posedge clock): all outputs, header_reg, the accumulator, temp_parity and the hold queue clear to 0. Reset mid-packet abandons the packet; no dout_valid follows.
- Header capture:
  - detect_add && pkt_valid && addr < NUM_PORTS: header_reg <= data_in.
  - Otherwise, when detect_add && pkt_valid: hdr_invalid <= 1 and header_reg is unchanged.
  - detect_add clears hold_ovf, hdr_invalid (unless set that same cycle), parity_done, err and the accumulator.
- lfd_state: dout <= header_reg, dout_valid = 1. The accumulator folds in header_reg.
- ld_state (payload and parity byte), with `hold empty` meaning the hold queue is empty:
  - !fifo_full and hold empty: dout <= data_in, dout_valid = 1.
  - !fifo_full and hold non-empty: pop head to dout and push data_in in the same cycle; count unchanged.
  - fifo_full: push data_in; dout_valid = 0.
- laf_state:
  - !fifo_full and hold non-empty: pop one entry per cycle to dout with dout_valid = 1.
  - Otherwise: idle.
- Hold queue order is strictly FIFO. Simultaneous push and pop leaves the count unchanged.
- Hold queue overflow: a push while full with no pop drops the byte and sets hold_ovf.
- dout_valid is registered alongside dout. dout holds its value when dout_valid = 0.
- Accumulator: every ld_state && pkt_valid byte is folded in, including bytes diverted to the hold queue. Folding uses XOR or a truncating add, per CHECK_MODE.
- Parity byte: ld_state && !pkt_valid captures data_in into temp_parity. The byte is also written/queued like payload, but is not folded into the accumulator.
- parity_done rises on the clock edge after parity-byte capture, then holds until detect_add or reset.
- err is registered one cycle after parity_done first rises: err = (temp_parity != accumulator). It holds until detect_add or reset.
- low_packet_valid: set on ld_state && pkt_valid; cleared on rst_int_reg or reset. Set wins over clear in the same cycle.
- FSM state inputs are one-hot. Behaviour with more than one state input asserted is undefined and flagged by assertion.

Decomposition:
- Shared package router_pkg holds:
  - CHECK_XOR = 0 and CHECK_SUM = 1.
  - A clog2 helper function.
  - Typedef for the addr_t header field slice.
- One sub-module, router_hold_fifo: a DEPTH x WIDTH circular queue with push, pop, count, full and empty, using pointer wrap at DEPTH.

Test Plan:
- Basic XOR packet, defaults:
  - Stimulus: header 0x0D (addr 1); payload 0x11, 0x22, 0x33; parity 0x0D; fifo_full = 0.
  - Required: dout_valid on 5 bytes in order, parity_done = 1, err = 0.
- Bad parity: same packet with parity 0x0C -> err = 1 one cycle after parity_done; err clears on next detect_add.
- Full stall:
  - Stimulus: fifo_full high during payload bytes 0x22 and 0x33.
  - Required: hold_count reaches 2 with no dout_valid; in laf_state with fifo_full low, dout = 0x22 then 0x33; accumulator still matches, err = 0.
- Overflow, HOLD_DEPTH = 2: three bytes while full -> hold_ovf = 1, third byte (0x44) never appears on dout.
- Invalid header: 0x0F (addr 3) -> hdr_invalid = 1, header_reg keeps its previous value.
- Sum mode and mid-packet reset:
  - CHECK_MODE = 1, header 0x0D, payload 0x11, 0x22, 0x33, parity 0x73 -> err = 0.
  - Assert resetn = 0 mid-payload -> all outputs 0 next cycle, hold_count = 0.
